maxnet_iter_ctrl: RTL and testbench

- Iterative winner-take-all (Maxnet) engine: latches four unsigned activations and repeatedly applies lateral inhibition.
- Drives the four per-neuron activity flags to the done checker and consumes its `done` verdict to terminate.
- Sits between the input loader and the result consumer in the Maxnet datapath.
- Reports the winning index, its residual value and the iteration count.

---
 rtl/maxnet_iter_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_maxnet_iter_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_iter_ctrl
// Description : Iterative winner-take-all (Maxnet) engine. Latches four
//               unsigned activations on start and then alternates a CHECK
//               cycle (done verdict / iteration cap) with an UPDATE cycle
//               applying lateral inhibition to all four lanes at once:
//                   x_i <= max(x_i - ((sum - x_i) >> SHIFT), 0)
//               When the run ends, the winning index, its residual value,
//               the iteration count and the termination reason are reported
//               together with a one-cycle valid strobe.
//
// Parameters  : WIDTH    - activation width (unsigned)
//               SHIFT    - inhibition factor epsilon = 2^-SHIFT
//               MAX_ITER - UPDATE-cycle cap (must fit in 8 bits)
//
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               start             - run request, sampled only when idle
//               in0..in3          - initial activations
//               done_in           - external checker verdict (one act bit set)
//               act[3:0]          - per-lane nonzero flags to the checker
//               busy              - run in progress
//               valid             - one-cycle result strobe
//               winner, win_val   - lowest nonzero lane and its value
//               iter_count        - UPDATE cycles executed
//               stall/timeout/none- termination reason / all-zero result
//
// Build option: MAXNET_INTERNAL_DONE_EN - when defined, the done verdict is
//               computed internally as "exactly one act bit set" and done_in
//               is ignored. Cycle timing is the same in both builds.
//
// Revision    : 1.0 - initial release
// ============================================================================
module maxnet_iter_ctrl #(
    parameter int WIDTH    = 8,
    parameter int SHIFT    = 2,
    parameter int MAX_ITER = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             done_in,
    output logic [3:0]       act,
    output logic             busy,
    output logic             valid,
    output logic [1:0]       winner,
    output logic [WIDTH-1:0] win_val,
    output logic [7:0]       iter_count,
    output logic             stall,
    output logic             timeout,
    output logic             none
);

    localparam logic [7:0] c_max_iter = 8'(MAX_ITER);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_UPDATE = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic [WIDTH-1:0] r_x  [4];
    logic [WIDTH-1:0] w_in [4];
    logic [WIDTH-1:0] w_nx [4];
    logic [WIDTH+1:0] w_sum;
    logic [3:0]       w_lane_changed;
    logic             w_changed;
    logic             w_done;
    logic [1:0]       w_win;

    assign w_in[0] = in0;
    assign w_in[1] = in1;
    assign w_in[2] = in2;
    assign w_in[3] = in3;

    // Two guard bits keep the four-way sum from overflowing.
    assign w_sum = {2'b00, r_x[0]} + {2'b00, r_x[1]}
                 + {2'b00, r_x[2]} + {2'b00, r_x[3]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [WIDTH+1:0] w_other;
            logic [WIDTH+1:0] w_dec;

            assign w_other = w_sum - {2'b00, r_x[gi]};
            assign w_dec   = w_other >> SHIFT;
            // Saturate at zero: only subtract when the decrement is smaller,
            // so the truncation back to WIDTH bits is lossless.
            assign w_nx[gi] = ({2'b00, r_x[gi]} > w_dec)
                            ? (r_x[gi] - w_dec[WIDTH-1:0])
                            : '0;
            assign w_lane_changed[gi] = (w_nx[gi] != r_x[gi]);
            assign act[gi]            = |r_x[gi];
        end
    endgenerate

    assign w_changed = |w_lane_changed;

`ifdef MAXNET_INTERNAL_DONE_EN
    // Exactly one bit set: nonzero and a power of two.
    assign w_done = (act != 4'b0000) && ((act & (act - 4'd1)) == 4'b0000);
`else
    assign w_done = done_in;
`endif

    // Lowest nonzero lane wins; lane 0 is reported when all are zero.
    always_comb begin
        w_win = 2'd0;
        if (act[0])      w_win = 2'd0;
        else if (act[1]) w_win = 2'd1;
        else if (act[2]) w_win = 2'd2;
        else if (act[3]) w_win = 2'd3;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nx = S_CHECK;
            // done has priority over the iteration cap.
            S_CHECK:  if (w_done || (iter_count == c_max_iter)) w_state_nx = S_FINISH;
                      else                                      w_state_nx = S_UPDATE;
            S_UPDATE: w_state_nx = w_changed ? S_CHECK : S_FINISH;
            S_FINISH: w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_x[i] <= '0;
            busy       <= 1'b0;
            valid      <= 1'b0;
            winner     <= 2'd0;
            win_val    <= '0;
            iter_count <= 8'd0;
            stall      <= 1'b0;
            timeout    <= 1'b0;
            none       <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 4; i++) r_x[i] <= w_in[i];
                        iter_count <= 8'd0;
                        stall      <= 1'b0;
                        timeout    <= 1'b0;
                        none       <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (!w_done && (iter_count == c_max_iter)) timeout <= 1'b1;
                end
                S_UPDATE: begin
                    for (int i = 0; i < 4; i++) r_x[i] <= w_nx[i];
                    iter_count <= iter_count + 8'd1;
                    if (!w_changed) stall <= 1'b1;
                end
                S_FINISH: begin
                    // Results, strobe and busy release all land on the edge
                    // that returns the FSM to IDLE.
                    valid   <= 1'b1;
                    winner  <= w_win;
                    win_val <= r_x[w_win];
                    none    <= ~|act;
                    busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_maxnet_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_maxnet_iter_ctrl
// Description : Scoreboard bench for maxnet_iter_ctrl. Two instances: one with
//               the default cap (255) and one with MAX_ITER=2. The external
//               done checker is modelled as "exactly one act bit set".
//               Expected results (including start-to-valid latency) are
//               hand-derived and queued at start; per-DUT monitors pop and
//               compare on every valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maxnet_iter_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A (MAX_ITER = 255) ----------------
    logic       a_start = 1'b0;
    logic [7:0] a_in [4];
    logic       a_done_in;
    logic [3:0] a_act;
    logic       a_busy, a_valid, a_stall, a_timeout, a_none;
    logic [1:0] a_winner;
    logic [7:0] a_win_val, a_iter;

    assign a_done_in = (a_act != 4'b0000) && ((a_act & (a_act - 4'd1)) == 4'b0000);

    maxnet_iter_ctrl #(.WIDTH(8), .SHIFT(2), .MAX_ITER(255)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start),
        .in0(a_in[0]), .in1(a_in[1]), .in2(a_in[2]), .in3(a_in[3]),
        .done_in(a_done_in), .act(a_act), .busy(a_busy), .valid(a_valid),
        .winner(a_winner), .win_val(a_win_val), .iter_count(a_iter),
        .stall(a_stall), .timeout(a_timeout), .none(a_none)
    );

    // ---------------- DUT B (MAX_ITER = 2) ----------------
    logic       b_start = 1'b0;
    logic [7:0] b_in [4];
    logic       b_done_in;
    logic [3:0] b_act;
    logic       b_busy, b_valid, b_stall, b_timeout, b_none;
    logic [1:0] b_winner;
    logic [7:0] b_win_val, b_iter;

    assign b_done_in = (b_act != 4'b0000) && ((b_act & (b_act - 4'd1)) == 4'b0000);

    maxnet_iter_ctrl #(.WIDTH(8), .SHIFT(2), .MAX_ITER(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start),
        .in0(b_in[0]), .in1(b_in[1]), .in2(b_in[2]), .in3(b_in[3]),
        .done_in(b_done_in), .act(b_act), .busy(b_busy), .valid(b_valid),
        .winner(b_winner), .win_val(b_win_val), .iter_count(b_iter),
        .stall(b_stall), .timeout(b_timeout), .none(b_none)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int winner;
        int win_val;
        int iter;
        int stall;
        int timeout;
        int none;
        int start_cyc;
        int lat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input int got, input int want);
        total_cnt++;
        if (got == want) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, want, $time);
    endtask

    always @(negedge clk) begin
        if (rst_n && a_valid) begin
            if (qa.size() == 0) begin
                chk("a_spurious_valid", 1, 0);
            end else begin
                ea = qa.pop_front();
                chk("a_winner",  int'(a_winner),  ea.winner);
                chk("a_win_val", int'(a_win_val), ea.win_val);
                chk("a_iter",    int'(a_iter),    ea.iter);
                chk("a_stall",   int'(a_stall),   ea.stall);
                chk("a_timeout", int'(a_timeout), ea.timeout);
                chk("a_none",    int'(a_none),    ea.none);
                chk("a_latency", cyc - ea.start_cyc, ea.lat);
                chk("a_busy_at_valid", int'(a_busy), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_valid) begin
            if (qb.size() == 0) begin
                chk("b_spurious_valid", 1, 0);
            end else begin
                eb = qb.pop_front();
                chk("b_winner",  int'(b_winner),  eb.winner);
                chk("b_win_val", int'(b_win_val), eb.win_val);
                chk("b_iter",    int'(b_iter),    eb.iter);
                chk("b_stall",   int'(b_stall),   eb.stall);
                chk("b_timeout", int'(b_timeout), eb.timeout);
                chk("b_none",    int'(b_none),    eb.none);
                chk("b_latency", cyc - eb.start_cyc, eb.lat);
                chk("b_busy_at_valid", int'(b_busy), 0);
            end
        end
    end

    task automatic wait_a();
        int n = 0;
        while (qa.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (qa.size() != 0) begin
            chk("a_result_timeout", 0, 1);
            qa.delete();
        end
    endtask

    task automatic wait_b();
        int n = 0;
        while (qb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (qb.size() != 0) begin
            chk("b_result_timeout", 0, 1);
            qb.delete();
        end
    endtask

    // Pulse start on DUT A and queue the hand-computed result.
    // Latency (start edge to valid): 2n+2 when ending from CHECK,
    // 2n+1 when ending on a stalled UPDATE (n = UPDATE cycles).
    task automatic run_a(input int i0, input int i1, input int i2, input int i3,
                         input int w, input int v, input int it,
                         input int st, input int to, input int no, input int lat);
        exp_t e;
        @(negedge clk);
        a_in[0] = 8'(i0); a_in[1] = 8'(i1); a_in[2] = 8'(i2); a_in[3] = 8'(i3);
        a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        e.winner = w; e.win_val = v; e.iter = it; e.stall = st;
        e.timeout = to; e.none = no; e.start_cyc = cyc; e.lat = lat;
        qa.push_back(e);
        wait_a();
    endtask

    initial begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            a_in[i] = 8'd0;
            b_in[i] = 8'd0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_a_busy",    int'(a_busy),    0);
        chk("rst_a_valid",   int'(a_valid),   0);
        chk("rst_a_act",     int'(a_act),     0);
        chk("rst_a_iter",    int'(a_iter),    0);
        chk("rst_a_win_val", int'(a_win_val), 0);
        chk("rst_a_flags",   int'({a_stall, a_timeout, a_none}), 0);
        chk("rst_b_busy",    int'(b_busy),    0);

        // Single nonzero lane: done at the first CHECK.
        run_a(100, 0, 0, 0,   0, 100, 0,  0, 0, 0, 2);
        // 80/40 -> {70,20} -> {65,3} -> {65,0}.
        run_a(80, 40, 0, 0,   0, 65,  3,  0, 0, 0, 8);

        // DUT B: cap at 2 updates -> timeout with {65,3}; extra start while busy.
        @(negedge clk);
        b_in[0] = 8'd80; b_in[1] = 8'd40; b_in[2] = 8'd0; b_in[3] = 8'd0;
        b_start = 1'b1;
        @(posedge clk);
        #1 b_start = 1'b0;
        e.winner = 0; e.win_val = 65; e.iter = 2; e.stall = 0;
        e.timeout = 1; e.none = 0; e.start_cyc = cyc; e.lat = 6;
        qb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        chk("b_busy_during_run", int'(b_busy), 1);
        b_start = 1'b1;
        @(posedge clk);
        #1 b_start = 1'b0;
        wait_b();
        repeat (10) @(negedge clk);
        chk("b_idle_after_run", int'(b_busy), 0);

        // Reset in the middle of the second UPDATE of the 80/40 case.
        @(negedge clk);
        a_in[0] = 8'd80; a_in[1] = 8'd40; a_in[2] = 8'd0; a_in[3] = 8'd0;
        a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_a_act_before_rst",  int'(a_act),  4'b0011);
        chk("mid_a_iter_before_rst", int'(a_iter), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_a_busy",    int'(a_busy),    0);
        chk("mid_rst_a_iter",    int'(a_iter),    0);
        chk("mid_rst_a_act",     int'(a_act),     0);
        chk("mid_rst_a_win_val", int'(a_win_val), 0);
        chk("mid_rst_b_timeout", int'(b_timeout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_a_valid", int'(a_valid), 0);

        // Clean rerun after reset.
        run_a(80, 40, 0, 0,   0, 65,  3,  0, 0, 0, 8);
        // 50/50 symmetric decay: 38,29,22,17,13,10,8,6,5,4,3 then 3>>2=0
        // leaves x unchanged on the 12th UPDATE.
        run_a(50, 50, 0, 0,   0, 3,   12, 1, 0, 0, 25);
        // All zero: one UPDATE changes nothing.
        run_a(0, 0, 0, 0,     0, 0,   1,  1, 0, 1, 3);
        // Only lane 3 nonzero: immediate done, winner index 3.
        run_a(0, 0, 0, 9,     3, 9,   0,  0, 0, 0, 2);
        // {0,20,0,60} -> {0,5,0,55} -> {0,0,0,54}.
        run_a(0, 20, 0, 60,   3, 54,  2,  0, 0, 0, 6);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
